// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences a single-cycle core through a self-checking run: holds its reset
// for a fixed number of cycles, releases it, gates its clock enable (free-run
// or single-step), and stops it when the pass/fail signature store appears or
// when the watchdog expires.
module cpu_run_controller #(
    parameter int          RESET_CYCLES = 2,
    parameter int          MAX_CYCLES   = 30,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] PASS_ADDR    = 32'd100,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] IGNORE_ADDR  = 32'd96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      fail_adr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Store classification results.
    localparam logic [1:0] STORE_NONE   = 2'd0;
    localparam logic [1:0] STORE_PASS   = 2'd1;
    localparam logic [1:0] STORE_IGNORE = 2'd2;
    localparam logic [1:0] STORE_FAIL   = 2'd3;

    localparam int               HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  WDOG_LIM  = CNT_W'(MAX_CYCLES);

    // Classifies a store; the pass signature is checked before the scratch
    // address so a correct pass store can never be swallowed as scratch.
    function automatic logic [1:0] classify_store(
        input logic        wr,
        input logic [31:0] adr,
        input logic [31:0] data
    );
        logic [1:0] cls;
        if (!wr) begin
            cls = STORE_NONE;
        end else if ((adr == PASS_ADDR) && (data == PASS_DATA)) begin
            cls = STORE_PASS;
        end else if (adr == IGNORE_ADDR) begin
            cls = STORE_IGNORE;
        end else begin
            cls = STORE_FAIL;
        end
        return cls;
    endfunction

    // Saturating increment so the count never wraps back to a small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       fail_adr_q, fail_adr_d;

    logic              run_en_s;
    logic [1:0]        store_cls_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic              cpu_reset_s;
    logic              cpu_en_s;
    logic              busy_s;

    // A RUN cycle counts only when the core is actually clocked.
    assign run_en_s    = (state_q == ST_RUN) && (!step_mode || step);
    assign store_cls_s = classify_store(MemWrite, DataAdr, WriteData);
    assign count_inc_s = sat_inc(count_q);

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= HOLD_ZERO;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= CNT_ZERO;
            fail_adr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            count_q    <= count_d;
            fail_adr_q <= fail_adr_d;
        end
    end

    // Next-state and status update: sequencing, store decision and watchdog.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        done_d     = done_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        count_d    = count_q;
        fail_adr_d = fail_adr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_HOLD;
                    hold_d     = HOLD_LOAD;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    count_d    = CNT_ZERO;
                    fail_adr_d = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_ZERO) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (run_en_s) begin
                    count_d = count_inc_s;
                    case (store_cls_s)
                        STORE_PASS: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end
                        STORE_FAIL: begin
                            state_d    = ST_DONE;
                            done_d     = 1'b1;
                            pass_d     = 1'b0;
                            fail_adr_d = DataAdr;
                        end
                        default: begin
                            // No store or scratch store: only the watchdog can end the run.
                            if (count_inc_s == WDOG_LIM) begin
                                state_d   = ST_DONE;
                                done_d    = 1'b1;
                                pass_d    = 1'b0;
                                timeout_d = 1'b1;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                    endcase
                end else begin
                    // Core frozen by single-step gating: stores are not real this cycle.
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Core control decode from the registered state; cpu_en follows step inputs directly.
    always_comb begin
        cpu_reset_s = 1'b0;
        cpu_en_s    = 1'b0;
        busy_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_reset_s = 1'b1;
            end
            ST_HOLD: begin
                cpu_reset_s = 1'b1;
                cpu_en_s    = 1'b1;
                busy_s      = 1'b1;
            end
            ST_RUN: begin
                cpu_en_s = !step_mode || step;
                busy_s   = 1'b1;
            end
            ST_DONE: begin
                cpu_reset_s = 1'b0;
            end
            default: begin
                cpu_reset_s = 1'b1;
            end
        endcase
    end

    assign cpu_reset   = cpu_reset_s;
    assign cpu_en      = cpu_en_s;
    assign busy        = busy_s;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;
    assign fail_adr    = fail_adr_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller: directed scenarios followed by random
// stimulus, every cycle compared against a run-level reference model.
module tb_cpu_run_controller;

    localparam int RESET_CYCLES = 2;
    localparam int MAX_CYCLES   = 30;
    localparam int CNT_W        = 16;
    localparam longint CNT_SAT  = (64'd1 << CNT_W) - 64'd1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        cpu_reset;
    logic        cpu_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [31:0] fail_adr;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: describes the run as "holding for N more cycles",
    // "running", "finished" or none of those (idle).
    int          m_hold_left;
    bit          m_running;
    bit          m_finished;
    longint      m_count;
    bit          m_pass;
    bit          m_timeout;
    logic [31:0] m_fail;

    cpu_run_controller #(
        .RESET_CYCLES(RESET_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .CNT_W       (CNT_W),
        .PASS_ADDR   (32'd100),
        .PASS_DATA   (32'd7),
        .IGNORE_ADDR (32'd96)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .cpu_reset  (cpu_reset),
        .cpu_en     (cpu_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .fail_adr   (fail_adr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_hold_left = 0;
        m_running   = 1'b0;
        m_finished  = 1'b0;
        m_count     = 0;
        m_pass      = 1'b0;
        m_timeout   = 1'b0;
        m_fail      = 32'd0;
    endtask

    task automatic m_finish(input bit p, input bit t, input logic [31:0] fa);
        m_running  = 1'b0;
        m_finished = 1'b1;
        m_pass     = p;
        m_timeout  = t;
        m_fail     = fa;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_update();
        if (!reset) begin
            m_reset();
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_running = 1'b1;
        end else if (m_running) begin
            if (!step_mode || step) begin
                if (m_count < CNT_SAT) m_count++;
                if (MemWrite && DataAdr == 32'd100 && WriteData == 32'd7)
                    m_finish(1'b1, 1'b0, 32'd0);
                else if (MemWrite && DataAdr == 32'd96)
                    m_running = 1'b1;
                else if (MemWrite)
                    m_finish(1'b0, 1'b0, DataAdr);
                if (m_running && m_count == MAX_CYCLES)
                    m_finish(1'b0, 1'b1, 32'd0);
            end
        end else if (start) begin
            m_reset();
            m_hold_left = RESET_CYCLES;
        end
    endtask

    task automatic compare_all();
        bit holding;
        holding = (m_hold_left > 0);
        check_val("cpu_reset", 32'(cpu_reset), 32'(!(m_running || m_finished)));
        check_val("busy", 32'(busy), 32'(holding || m_running));
        check_val("cpu_en", 32'(cpu_en), 32'(holding || (m_running && (!step_mode || step))));
        check_val("done", 32'(done), 32'(m_finished));
        check_val("pass", 32'(pass), 32'(m_pass));
        check_val("timeout", 32'(timeout), 32'(m_timeout));
        check_val("cycle_count", 32'(cycle_count), 32'(m_count));
        check_val("fail_adr", fail_adr, m_fail);
    endtask

    // One clock: compare on the falling edge, update the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Start pulse plus the reset hold; returns at the first RUN cycle.
    task automatic go_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RESET_CYCLES) begin
            check_val("hold_cpu_reset", 32'(cpu_reset), 32'd1);
            tick();
        end
        check_val("run_cpu_reset", 32'(cpu_reset), 32'd0);
    endtask

    task automatic run_idle(input int n);
        MemWrite = 1'b0;
        repeat (n) tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; step_mode = 1'b0; step = 1'b0;
        MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
        @(posedge clk);
        #1;
        m_reset();

        // 1. reset held with start asserted
        tick();
        check_val("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_val("rst_cpu_en", 32'(cpu_en), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_count", 32'(cycle_count), 32'd0);
        reset = 1'b1; start = 1'b0;
        tick();

        // 2. pass run with a scratch store first
        go_start();
        run_idle(2);
        store(32'd96, 32'd5);
        run_idle(1);
        store(32'd100, 32'd7);
        check_val("p2_done", 32'(done), 32'd1);
        check_val("p2_pass", 32'(pass), 32'd1);
        check_val("p2_count", 32'(cycle_count), 32'd5);
        check_val("p2_cpu_en", 32'(cpu_en), 32'd0);
        check_val("p2_cpu_reset", 32'(cpu_reset), 32'd0);

        // 3. fail on wrong data at pass address, then on another address
        go_start();
        run_idle(1);
        store(32'd100, 32'd9);
        check_val("p3_done", 32'(done), 32'd1);
        check_val("p3_pass", 32'(pass), 32'd0);
        check_val("p3_timeout", 32'(timeout), 32'd0);
        check_val("p3_fail_adr", fail_adr, 32'd100);
        check_val("p3_count", 32'(cycle_count), 32'd2);
        go_start();
        run_idle(1);
        store(32'd80, 32'd1234);
        check_val("p3b_fail_adr", fail_adr, 32'd80);

        // 4. watchdog, then a pass store on the very last cycle
        go_start();
        run_idle(MAX_CYCLES);
        check_val("p4_timeout", 32'(timeout), 32'd1);
        check_val("p4_pass", 32'(pass), 32'd0);
        check_val("p4_count", 32'(cycle_count), 32'(MAX_CYCLES));
        go_start();
        run_idle(MAX_CYCLES - 1);
        store(32'd100, 32'd7);
        check_val("p4b_pass", 32'(pass), 32'd1);
        check_val("p4b_timeout", 32'(timeout), 32'd0);

        // 5. single-step: stores while step is low are ignored
        step_mode = 1'b1;
        go_start();
        repeat (3) begin
            MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd7; step = 1'b0;
            tick(); tick();
            MemWrite = 1'b0; step = 1'b1;
            tick();
            step = 1'b0;
        end
        check_val("p5_done", 32'(done), 32'd0);
        check_val("p5_count", 32'(cycle_count), 32'd3);
        step = 1'b1;
        store(32'd100, 32'd7);
        step = 1'b0;
        check_val("p5_pass", 32'(pass), 32'd1);
        check_val("p5_count4", 32'(cycle_count), 32'd4);
        step_mode = 1'b0;

        // 6. reset in RUN, then restart from DONE
        go_start();
        run_idle(4);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_val("p6_busy", 32'(busy), 32'd0);
        check_val("p6_cpu_reset", 32'(cpu_reset), 32'd1);
        check_val("p6_count", 32'(cycle_count), 32'd0);
        go_start();
        run_idle(2);
        store(32'd100, 32'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("p6_done_clr", 32'(done), 32'd0);
        check_val("p6_busy_hold", 32'(busy), 32'd1);
        check_val("p6_count_clr", 32'(cycle_count), 32'd0);
        tick();
        tick();
        run_idle(3);
        store(32'd200, 32'd1);
        check_val("p6_fail_adr", fail_adr, 32'd200);
        check_val("p6_count4", 32'(cycle_count), 32'd4);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            int sel;
            reset     = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
            step      = $urandom_range(0, 1);
            MemWrite  = ($urandom_range(0, 9) == 0);
            sel       = $urandom_range(0, 3);
            case (sel)
                0: DataAdr = 32'd100;
                1: DataAdr = 32'd96;
                2: DataAdr = 32'd80;
                default: DataAdr = $urandom;
            endcase
            WriteData = ($urandom_range(0, 1) == 0) ? 32'd7 : 32'($urandom_range(0, 15));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
